// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: 2-entry buffer feeding the register file write port
module wb_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             flush,
    input  logic             wb_hold,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_wr_en,
    input  logic             in_full_addr,
    input  logic [2:0]       in_reg_src,
    input  logic [3:0]       in_reg_full,
    input  logic             in_special_op,
    input  logic [2:0]       in_special_func,
    input  logic             in_sel_mem,
    input  logic [7:0]       in_alu_result,
    input  logic [7:0]       in_mem_data,
    output logic             write_reg,
    output logic             full_addr,
    output logic [2:0]       write_reg_src,
    output logic [3:0]       write_reg_full,
    output logic             special_op,
    output logic [2:0]       special_func,
    output logic [7:0]       data_in,
    output logic             fwd_valid,
    output logic [7:0]       fwd_data,
    output logic [CNT_W-1:0] retire_count
);

    typedef struct packed {
        logic       wr_en;
        logic       full_addr;
        logic [2:0] reg_src;
        logic [3:0] reg_full;
        logic       special_op;
        logic [2:0] special_func;
        logic [7:0] data;
    } entry_t;

    entry_t           slot_q [2];
    entry_t           head;
    entry_t           in_entry;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic [CNT_W-1:0] retire_q;
    logic             not_empty;
    logic             push;
    logic             pop;
    logic             zero_dst;

    // Only the muxed result is kept; the select bit dies here.
    always_comb begin
        in_entry.wr_en        = in_wr_en;
        in_entry.full_addr    = in_full_addr;
        in_entry.reg_src      = in_reg_src;
        in_entry.reg_full     = in_reg_full;
        in_entry.special_op   = in_special_op;
        in_entry.special_func = in_special_func;
        in_entry.data         = in_sel_mem ? in_mem_data : in_alu_result;
    end

    assign head      = slot_q[rd_ptr];
    assign not_empty = (count != 2'd0);
    assign in_ready  = (count < 2'(DEPTH));
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = not_empty & ~wb_hold & ~flush;
    assign zero_dst  = head.full_addr & (head.reg_full == 4'b0000);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            retire_q <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                retire_q <= retire_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: every output is gated by count.
    always_ff @(posedge CLK) begin
        if (RST_N && push) begin
            slot_q[wr_ptr] <= in_entry;
        end
    end

    always_comb begin
        write_reg      = 1'b0;
        full_addr      = 1'b0;
        write_reg_src  = 3'd0;
        write_reg_full = 4'd0;
        special_op     = 1'b0;
        special_func   = 3'd0;
        data_in        = 8'd0;
        fwd_valid      = 1'b0;
        fwd_data       = 8'd0;
        if (not_empty) begin
            write_reg      = head.wr_en & ~wb_hold & ~flush & ~zero_dst;
            full_addr      = head.full_addr;
            write_reg_src  = head.reg_src;
            write_reg_full = head.reg_full;
            special_op     = head.special_op;
            special_func   = head.special_func;
            data_in        = head.data;
            fwd_valid      = head.wr_en;
            fwd_data       = head.data;
        end
    end

    assign retire_count = retire_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage directly upstream of the register file.
- Accepts completed instructions from the execute/memory stage over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Selects the ALU or memory result for each instruction and drives the register file's write-side inputs one instruction per cycle.
- Exports forwarding info for the head entry and a retired-instruction counter.

Parameters:
DEPTH, 2, buffer entries (only 2 supported)
CNT_W, 8, width of retire_count

Ports:
CLK  input  1  clock, all state updates on posedge
RST_N  input  1  synchronous active-low reset
flush  input  1  discard all buffered entries this edge
wb_hold  input  1  stall: head entry not committed this edge
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept an entry this cycle
in_wr_en  input  1  instruction writes a register
in_full_addr  input  1  use 4-bit full register address
in_reg_src  input  3  banked destination register
in_reg_full  input  4  full destination register
in_special_op  input  1  special-op instruction
in_special_func  input  3  special function code
in_sel_mem  input  1  1: result from memory, 0: from ALU
in_alu_result  input  8  ALU result
in_mem_data  input  8  load data
write_reg  output  1  register file write enable
full_addr  output  1  to register file
write_reg_src  output  3  to register file
write_reg_full  output  4  to register file
special_op  output  1  to register file
special_func  output  3  to register file
data_in  output  8  write data to register file
fwd_valid  output  1  head entry will write a register
fwd_data  output  8  head entry write data
retire_count  output  CNT_W  committed-instruction count

Behaviour:
- Reset (RST_N low at posedge): FIFO empty, read/write pointers 0, retire_count 0. All write-side and fwd outputs read 0. in_ready reads 1 after the reset edge. Reset overrides flush, enqueue and commit.
- Entry contents: wr_en, full_addr, reg_src, reg_full, special_op, special_func, data. data = in_sel_mem ? in_mem_data : in_alu_result, captured at enqueue. The mux result is stored; the select bit is not.
- in_ready = (count < 2). It depends on registered count only. There is no combinational path from wb_hold, flush or commit.
- Enqueue: in_valid & in_ready at posedge writes the tail entry.
- Commit: count > 0 & !wb_hold at posedge pops the head entry and increments retire_count. retire_count wraps 2^CNT_W-1 -> 0. Entries with wr_en=0 still commit and count.
- Enqueue and commit on the same edge: count unchanged and both take effect. With count=1, the new entry becomes head next cycle.
- Latency: an entry enqueued at edge N into an empty FIFO is presented during cycle N+1 and committed at edge N+1 if not held.
- Outputs are combinational from the head entry when count > 0. When empty, all are 0.
  - write_reg = head.wr_en & !wb_hold & !(head.full_addr & head.reg_full==4'b0000). Writes to hard-zero register 0 are suppressed but still retire.
  - full_addr, write_reg_src, write_reg_full, special_op, special_func, data_in = head fields.
- fwd_valid = (count > 0) & head.wr_en. It is unaffected by wb_hold. fwd_data = head.data.
- Flush at posedge: count -> 0 and the same-edge enqueue is dropped. The head's commit is also suppressed: no retire increment and no write that edge. write_reg is combinationally forced to 0 while flush is high.
- Hold while full: in_ready stays 0 and outputs stay stable on the same head.

Test Plan:
- Reset then single ALU op (in_wr_en=1, full_addr=0, reg_src=3, sel_mem=0, alu=8'h5A) -> cycle after enqueue: write_reg=1, write_reg_src=3, data_in=8'h5A. Next cycle empty, outputs 0, retire_count=1.
- Load with sel_mem=1, mem=8'hC3, alu=8'h11, full_addr=1, reg_full=4'b1001 -> data_in=8'hC3, write_reg_full=9, fwd_valid=1, fwd_data=8'hC3.
- wb_hold high for 3 cycles while sending 3 back-to-back ops -> in_ready drops after 2 accepted. write_reg=0 during hold. Release -> 2 commits in order on consecutive edges, 3rd accepted once a slot frees. retire_count ends at 3.
- full_addr=1, reg_full=0, wr_en=1, data 8'hFF -> write_reg stays 0, retire_count increments by 1.
- Fill FIFO (2 entries), assert flush with in_valid=1 -> next cycle count=0, in_ready=1, no write occurred, retire_count unchanged.
- 256 commits of wr_en=0 ops with CNT_W=8 -> retire_count wraps to 0 and write_reg never asserted. Then RST_N=0 mid-stream with 1 entry buffered -> all outputs 0 and FIFO empty next cycle.
